// File: rtl/dmem_responder.sv
// Data-memory responder for a single-cycle RV32I core: word RAM with byte/halfword lanes
// plus an MMIO window holding a byte TX FIFO, a status register and a free-running cycle counter.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        mem_err
);
  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [PW:0] FULL_CNT  = (PW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic [31:0]   ram_q [DEPTH_WORDS];
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic [31:0]   cycle_q, cycle_d;
  logic          misalign_q, misalign_d, overflow_q, overflow_d, mem_err_q;

  // Lane select and extension of a RAM word; misaligned or unknown sizes read as zero.
  function automatic logic [31:0] load_ext(input logic [31:0] word, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic        [7:0]  b;
    logic signed [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      F_B:     load_ext = 32'($signed(b));
      F_BU:    load_ext = {24'b0, b};
      F_H:     load_ext = off[0] ? 32'b0 : 32'(h);
      F_HU:    load_ext = off[0] ? 32'b0 : {16'b0, h};
      F_W:     load_ext = (off != 2'b00) ? 32'b0 : word;
      default: load_ext = 32'b0;
    endcase
  endfunction

  logic          in_ram, hit_tx, hit_st, hit_cy, is_word;
  logic          misaligned_st, st_ok, ram_we, mmio_we;
  logic          push_req, status_we, cycle_we;
  logic          fifo_empty, fifo_full, pop, push, drop;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   wdata;

  assign in_ram  = Addr < RAM_BYTES;
  assign widx    = Addr[AW+1:2];
  assign hit_tx  = Addr == MMIO_BASE;
  assign hit_st  = Addr == MMIO_BASE + 32'd4;
  assign hit_cy  = Addr == MMIO_BASE + 32'd8;
  assign is_word = funct3 == F_W;

  assign misaligned_st = ((funct3 == F_H) && Addr[0]) || (is_word && (Addr[1:0] != 2'b00));
  assign st_ok     = MemWrite && (funct3 inside {F_B, F_H, F_W}) && !misaligned_st;
  assign ram_we    = st_ok && in_ram;
  assign mmio_we   = MemWrite && is_word;
  assign push_req  = mmio_we && hit_tx;
  assign status_we = mmio_we && hit_st;
  assign cycle_we  = mmio_we && hit_cy;

  // Pop is evaluated first so a push into a full FIFO still lands when the head leaves.
  assign fifo_empty = count_q == '0;
  assign fifo_full  = count_q == FULL_CNT;
  assign pop        = !fifo_empty && tx_ready;
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_comb begin
    be    = 4'b0000;
    wdata = WriteData;
    case (funct3)
      F_B: begin
        be    = 4'b0001 << Addr[1:0];
        wdata = {4{WriteData[7:0]}};
      end
      F_H: begin
        be    = Addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{WriteData[15:0]}};
      end
      F_W:     be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    count_d    = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
    cycle_d    = cycle_we ? WriteData : cycle_q + 32'd1;
    misalign_d = (misalign_q && !(status_we && WriteData[2])) || (MemWrite && misaligned_st);
    overflow_d = (overflow_q && !(status_we && WriteData[3])) || drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      cycle_q    <= '0;
      misalign_q <= 1'b0;
      overflow_q <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      cycle_q    <= cycle_d;
      misalign_q <= misalign_d;
      overflow_q <= overflow_d;
      mem_err_q  <= misalign_d | overflow_d;
    end
  end

  // Storage arrays carry no reset; rst only suppresses a store landing on the same edge.
  always_ff @(posedge clk) begin
    if (!rst && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram_q[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (!rst && push) fifo_q[wr_ptr_q] <= WriteData[7:0];
  end

  always_comb begin
    ReadData = 32'b0;
    if (in_ram) begin
      ReadData = load_ext(ram_q[widx], funct3, Addr[1:0]);
    end else if (is_word) begin
      if (hit_st)      ReadData = {27'b0, 1'b0, overflow_q, misalign_q, fifo_full, fifo_empty};
      else if (hit_cy) ReadData = cycle_q;
    end
  end

  assign tx_valid = !fifo_empty;
  assign tx_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign mem_err  = mem_err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes, misalignment, TX FIFO, status and cycle counter.
module tb_dmem_responder;
  logic        clk, rst, MemWrite, tx_ready, tx_valid, mem_err;
  logic [2:0]  funct3;
  logic [31:0] Addr, WriteData, ReadData;
  logic [7:0]  tx_data;
  int checks = 0;
  int errors = 0;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
  localparam logic [31:0] TXD = 32'h1000, STS = 32'h1004, CYC = 32'h1008;

  dmem_responder dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .funct3(funct3), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Inputs change in the low phase; the store commits on the following rising edge.
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
    MemWrite = 1'b1; Addr = a; WriteData = d; funct3 = f;
    @(negedge clk);
    MemWrite = 1'b0;
    #1;
  endtask

  task automatic ld(input logic [31:0] a, input logic [2:0] f);
    MemWrite = 1'b0; Addr = a; funct3 = f;
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_txvalid got %b exp 0", tx_valid); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_txdata got %h exp 00", tx_data); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL rst_memerr got %b exp 0", mem_err); end
    ld(STS, LW);
    checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL rst_status got %h exp 00000001", ReadData); end
    ld(CYC, LW);
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL rst_cycle got %h exp 00000000", ReadData); end
    rst = 1'b0;
  endtask

  task automatic test_loads();
    st(32'h10, 32'hDEADBEEF, LW);
    ld(32'h10, LW);  checks++; if (ReadData !== 32'hDEADBEEF) begin errors++; $display("FAIL lw got %h exp deadbeef", ReadData); end
    ld(32'h10, LB);  checks++; if (ReadData !== 32'hFFFFFFEF) begin errors++; $display("FAIL lb got %h exp ffffffef", ReadData); end
    ld(32'h10, LBU); checks++; if (ReadData !== 32'h000000EF) begin errors++; $display("FAIL lbu got %h exp 000000ef", ReadData); end
    ld(32'h10, LH);  checks++; if (ReadData !== 32'hFFFFBEEF) begin errors++; $display("FAIL lh got %h exp ffffbeef", ReadData); end
    ld(32'h12, LHU); checks++; if (ReadData !== 32'h0000DEAD) begin errors++; $display("FAIL lhu got %h exp 0000dead", ReadData); end
    ld(32'h13, LB);  checks++; if (ReadData !== 32'hFFFFFFDE) begin errors++; $display("FAIL lb3 got %h exp ffffffde", ReadData); end
    ld(32'h11, LW);  checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL lw_mis got %h exp 0", ReadData); end
    ld(32'h11, LH);  checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL lh_mis got %h exp 0", ReadData); end
    ld(32'h10, 3'b011); checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL bad_f3 got %h exp 0", ReadData); end
    ld(32'h2000, LW); checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL unmapped got %h exp 0", ReadData); end
    ld(STS, LB);     checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL mmio_sub got %h exp 0", ReadData); end
  endtask

  task automatic test_partial_stores();
    st(32'h11, 32'h55, LB);
    ld(32'h10, LW); checks++; if (ReadData !== 32'hDEAD55EF) begin errors++; $display("FAIL sb got %h exp dead55ef", ReadData); end
    st(32'h12, 32'h1234, LH);
    ld(32'h10, LW); checks++; if (ReadData !== 32'h123455EF) begin errors++; $display("FAIL sh got %h exp 123455ef", ReadData); end
  endtask

  task automatic test_misalign();
    st(32'h12, 32'hFFFFFFFF, LW);
    ld(32'h10, LW); checks++; if (ReadData !== 32'h123455EF) begin errors++; $display("FAIL mis_nowrite got %h exp 123455ef", ReadData); end
    ld(STS, LW);    checks++; if (ReadData !== 32'h5) begin errors++; $display("FAIL mis_status got %h exp 00000005", ReadData); end
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL mis_memerr got %b exp 1", mem_err); end
    st(STS, 32'h4, LW);
    ld(STS, LW);    checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL mis_clear got %h exp 00000001", ReadData); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL mis_clr_memerr got %b exp 0", mem_err); end
  endtask

  task automatic test_overflow();
    tx_ready = 1'b0;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ov_idle got %b exp 0", tx_valid); end
    for (int i = 0; i < 4; i++) st(TXD, 32'h41 + i, LW);
    ld(STS, LW); checks++; if (ReadData !== 32'h2) begin errors++; $display("FAIL ov_full got %h exp 00000002", ReadData); end
    st(TXD, 32'h45, LW);
    ld(STS, LW); checks++; if (ReadData !== 32'hA) begin errors++; $display("FAIL ov_status got %h exp 0000000a", ReadData); end
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL ov_memerr got %b exp 1", mem_err); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'(8'h41 + i)) begin
        errors++; $display("FAIL ov_drain%0d got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'(8'h41 + i));
      end
      @(negedge clk); #1;
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ov_empty got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
    st(STS, 32'h8, LW);
    ld(STS, LW); checks++; if (ReadData !== 32'h1) begin errors++; $display("FAIL ov_clear got %h exp 00000001", ReadData); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL ov_clr_memerr got %b exp 0", mem_err); end
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) st(TXD, 32'h60 + i, LW);
    tx_ready = 1'b1;
    MemWrite = 1'b1; Addr = TXD; WriteData = 32'h50; funct3 = LW;
    @(negedge clk);
    MemWrite = 1'b0; tx_ready = 1'b0;
    ld(STS, LW); checks++; if (ReadData !== 32'h2) begin errors++; $display("FAIL b2b_status got %h exp 00000002", ReadData); end
    checks++; if (tx_data !== 8'h61) begin errors++; $display("FAIL b2b_head got %h exp 61", tx_data); end
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] e;
      e = (i == 3) ? 8'h50 : 8'(8'h61 + i);
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== e) begin
        errors++; $display("FAIL b2b_drain%0d got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, e);
      end
      @(negedge clk); #1;
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_cycle_and_reset();
    st(CYC, 32'hFFFFFFFE, LW);
    ld(CYC, LW); checks++; if (ReadData !== 32'hFFFFFFFE) begin errors++; $display("FAIL cyc0 got %h exp fffffffe", ReadData); end
    @(negedge clk); #1;
    checks++; if (ReadData !== 32'hFFFFFFFF) begin errors++; $display("FAIL cyc1 got %h exp ffffffff", ReadData); end
    @(negedge clk); #1;
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL cyc_wrap got %h exp 00000000", ReadData); end
    st(TXD, 32'h77, LW);
    ld(CYC, LW);
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid got %b exp 1", tx_valid); end
    rst = 1'b1; #1;
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", tx_valid); end
    checks++; if (ReadData !== 32'h0) begin errors++; $display("FAIL mid_rst_cycle got %h exp 00000000", ReadData); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL mid_rst_txdata got %h exp 00", tx_data); end
    @(negedge clk); rst = 1'b0; #1;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; MemWrite = 1'b0; funct3 = 3'b0; Addr = 32'b0;
    WriteData = 32'b0; tx_ready = 1'b0;
    test_reset();
    test_loads();
    test_partial_stores();
    test_misalign();
    test_overflow();
    test_back_to_back();
    test_cycle_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
